alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Small multi-cycle ALU with a valid/ready input handshake. Accepts two DW-bit
//  unsigned operands and a 2-bit opcode, computes add/sub/mul/and, and holds the
//  result on a registered output until the next operation completes.
//  Sits behind any producer that issues one operation per handshake.
//  No output-side handshake exists; ready returning high marks the result valid.
// PARAMETERS
//  DW        4         operand width in bits
//  RW        2*DW+1    result width (9 at default); derived, do not override
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    asynchronous, active-low reset (0 = in reset)
//  data1     in   DW   operand A, unsigned
//  data2     in   DW   operand B, unsigned
//  control   in   2    opcode: 00 ADD, 01 SUB, 10 MUL, 11 AND
//  valid     in   1    producer has an operation on data1/data2/control
//  ready     out  1    ALU idle and able to accept; also result-valid flag
//  result    out  RW   last completed result, registered
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset (reset=0): state=RST, ready=0, result=0, all internal regs cleared.
//  - FSM states:
//    - RST -> IDLE on the first posedge after reset deasserts; ready becomes 1.
//    - IDLE (ready=1): at a posedge with valid=1, the handshake fires.
//      - Capture data1, data2 and control into internal regs.
//      - Set ready=0 and go to EXEC.
//      - With valid=0, stay in IDLE.
//    - EXEC, opcode ADD/SUB/AND: single cycle.
//      - At the next posedge: update result, set ready=1, return to IDLE.
//    - EXEC, opcode MUL: iterative shift-add over DW cycles, one multiplier bit per cycle (LSB first).
//      - On the DW-th posedge after accept: update result, set ready=1, return to IDLE.
//  - Latency, counted from the accept edge to the edge that raises ready:
//    - ADD/SUB/AND: 1 cycle.
//    - MUL: DW cycles (4 at default).
//  - Arithmetic, all results RW bits:
//    - ADD: zero-extended A+B. Max 15+15 = 9'h01E.
//    - SUB: A-B in RW-bit two's complement. 3-5 = 9'h1FE; 5-3 = 9'h002.
//    - MUL: A*B zero-extended. 15*15 = 9'h0E1.
//    - AND: zero-extended A&B.
//  - While in EXEC:
//    - result keeps the previous completed value; it never shows partial products.
//    - data1/data2/control/valid are ignored; changing the inputs mid-operation has no effect.
//  - valid held high continuously: a new operation is accepted on the posedge right after ready rises.
//    - Back-to-back throughput is therefore one op per latency+1 cycles.
//  - ready rising and a new accept never happen on the same edge.
//  - Reset mid-operation: aborts immediately; result=0, ready=0, then RST -> IDLE as above.
//  - No X propagation: all registers are reset.
// STRUCTURE
//  - Package alu_pkg:
//    - opcode enum: ADD=2'b00, SUB=2'b01, MUL=2'b10, AND=2'b11
//    - FSM state enum: RST, IDLE, EXEC
//    - DW/RW constants
//  - Sub-module alu_mul_seq: sequential shift-add multiplier.
//    - Inputs: start, a, b. Outputs: done, product.
//    - Owns the bit counter and partial-sum register.
//  - Top alu holds the FSM, the operand capture regs and the single-cycle ops.
// TESTING
//  - Reset: hold reset=0 for 7 ns -> ready=0, result=0.
//    - After release, ready=1 at the first posedge.
//  - ADD: 15,15,op 00 with valid=1 -> ready drops for 1 cycle, then result=9'h01E, ready=1.
//  - SUB: 3,5,op 01 -> result=9'h1FE after 1 cycle; then 5,3 -> 9'h002.
//  - MUL: 15,15,op 10 -> ready low for exactly 4 cycles, result=9'h0E1.
//    - result keeps its prior value during those cycles.
//  - Inputs changed mid-MUL, valid held high:
//    - result reflects only the captured operands.
//    - The next op is accepted on the edge after ready rises.
//  - Reset asserted during MUL -> result=0, ready=0 at once; normal recovery after release.
//  - Random: 20+ ops with random idle delays. Checks:
//    - Every accepted op yields exactly one result.
//    - result matches the model for every accepted op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: widths, opcodes and FSM states.
package alu_pkg;

  // Default operand width and the derived result width (room for a full product plus one).
  localparam int ALU_DW = 4;
  localparam int ALU_RW = 2 * ALU_DW + 1;

  // Opcode encoding as seen on the control input.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  // Controller states. RST is held while reset is asserted and left on the first clock after.
  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_IDLE = 2'b01,
    ST_EXEC = 2'b10
  } alu_state_e;

  // Only the multiply needs more than one execute cycle.
  function automatic logic is_multi_cycle(alu_op_e op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first.
// A start pulse loads the operands; exactly DW clocks later done pulses high for one
// cycle, and product carries the final sum during that cycle. product is only
// meaningful while done is high.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW,
  localparam int RW = 2 * DW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [RW-1:0] product
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [RW-1:0] sum_next;

  // Next-state for the iteration registers; done and product are driven combinationally
  // so the caller can capture the finished product on the same edge as the last step.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done     = 1'b0;
    sum_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    product  = sum_next;

    if (start) begin
      acc_d    = '0;
      mcand_d  = {{(RW - DW){1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = sum_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        done   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Iteration registers; an asynchronous reset aborts any multiply in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu.sv
// Multi-cycle ALU: ADD/SUB/AND complete one clock after accept, MUL completes DW clocks
// after accept via the shift-add sub-module. result is registered and only changes
// when an operation completes.
//
// Handshake: an operation is accepted on a rising edge where valid=1 and ready=1.
// ready drops on that edge and rises again on the edge that writes the result, so
// ready high also means result holds the last completed operation. Inputs are ignored
// while ready is low, and a rising ready never coincides with an accept.
module alu
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW,
  localparam int RW = 2 * DW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  input  logic [1:0]    control,
  input  logic          valid,
  output logic          ready,
  output logic [RW-1:0] result
);

  alu_state_e    state_q, state_d;
  logic          ready_q, ready_d;
  logic [RW-1:0] result_q, result_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  alu_op_e       op_q, op_d;

  logic          mul_start;
  logic          mul_done;
  logic [RW-1:0] mul_product;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] single_res;

  assign a_ext = {{(RW - DW){1'b0}}, a_q};
  assign b_ext = {{(RW - DW){1'b0}}, b_q};

  // The multiplier loads straight from the inputs on the accept edge so that its
  // DW iterations line up with the DW-cycle latency.
  alu_mul_seq #(
    .DW(DW)
  ) u_mul (
    .clk    (clk),
    .rst_n  (reset),
    .start  (mul_start),
    .a      (data1),
    .b      (data2),
    .done   (mul_done),
    .product(mul_product)
  );

  // Single-cycle datapath on the captured operands; SUB wraps in RW-bit two's complement.
  always_comb begin
    single_res = '0;
    case (op_q)
      OP_ADD:  single_res = a_ext + b_ext;
      OP_SUB:  single_res = a_ext - b_ext;
      OP_AND:  single_res = a_ext & b_ext;
      default: single_res = '0;
    endcase
  end

  // Controller: next state, operand capture, result update and ready generation.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    result_d  = result_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    mul_start = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      ST_IDLE: begin
        if (valid) begin
          a_d       = data1;
          b_d       = data2;
          op_d      = alu_op_e'(control);
          mul_start = is_multi_cycle(alu_op_e'(control));
          ready_d   = 1'b0;
          state_d   = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_multi_cycle(op_q)) begin
          if (mul_done) begin
            result_d = mul_product;
            ready_d  = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          result_d = single_res;
          ready_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_RST;
        ready_d = 1'b0;
      end
    endcase
  end

  // Controller registers; reset clears everything and aborts any operation at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RST;
      ready_q  <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the multi-cycle ALU: directed corner cases, reset abort,
// back-to-back accepts with inputs changing mid-operation, and a randomized run
// scored against an arithmetic reference model.
module tb_alu;

  localparam int DW       = 4;
  localparam int RW       = 2 * DW + 1;
  localparam int MAX_WAIT = 20;

  // Clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic [1:0]    control;
  logic          valid;
  logic          ready;
  logic [RW-1:0] result;

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_exp;
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_res = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .data1  (data1),
    .data2  (data2),
    .control(control),
    .valid  (valid),
    .ready  (ready),
    .result (result)
  );

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic reduced modulo 2**RW.
  function automatic logic [RW-1:0] ref_result(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = a & b;
    endcase
    r = r & ((1 << RW) - 1);
    return r[RW-1:0];
  endfunction

  function automatic int ref_latency(input int op);
    return (op == 2) ? DW : 1;
  endfunction

  // Drive junk on the operand/opcode inputs; keep decides whether valid stays high.
  task automatic scramble(input bit keep);
    data1   = DW'($urandom_range(0, (1 << DW) - 1));
    data2   = DW'($urandom_range(0, (1 << DW) - 1));
    control = 2'($urandom_range(0, 3));
    valid   = keep;
  endtask

  // Issue one operation at a negedge where ready is high, then follow it to completion.
  // With hold=1, valid stays high with junk inputs during execution so the caller can
  // present the next operation right at the negedge where ready is seen high.
  task automatic do_op(input int a, input int b, input int op, input bit hold);
    int cyc;
    logic [RW-1:0] exp;
    check_eq("ready_before_issue", int'(ready), 1);
    data1   = DW'(a);
    data2   = DW'(b);
    control = 2'(op);
    valid   = 1'b1;
    exp_q.push_back(ref_result(a, b, op));
    n_acc++;
    @(posedge clk);
    #1;
    scramble(hold);
    @(negedge clk);
    check_eq("ready_drop", int'(ready), 0);
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ready) break;
      check_eq("result_hold", int'(result), int'(last_exp));
      if (cyc >= MAX_WAIT) begin
        check_eq("ready_timeout", int'(ready), 1);
        break;
      end
      scramble(hold);
    end
    check_eq("latency", cyc, ref_latency(op));
    exp = exp_q.pop_front();
    n_res++;
    check_eq("result", int'(result), int'(exp));
    last_exp = exp;
  endtask

  // Idle cycles: no spurious completion, result stable.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_ready", int'(ready), 1);
      check_eq("idle_result", int'(result), int'(last_exp));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    valid    = 1'b0;
    data1    = '0;
    data2    = '0;
    control  = 2'b00;
    last_exp = '0;

    // Reset held for 7 ns, then the first posedge must raise ready.
    #3;
    check_eq("reset_ready", int'(ready), 0);
    check_eq("reset_result", int'(result), 0);
    #4;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("release_ready", int'(ready), 1);
    check_eq("release_result", int'(result), 0);

    // Directed corners.
    do_op(15, 15, 0, 1'b0);   // 9'h01E
    idle(1);
    do_op(3, 5, 1, 1'b0);     // 9'h1FE
    do_op(5, 3, 1, 1'b0);     // 9'h002
    idle(2);
    do_op(15, 15, 2, 1'b0);   // 9'h0E1 after 4 cycles
    idle(1);
    do_op(0, 9, 2, 1'b0);
    do_op(12, 10, 3, 1'b0);

    // Back-to-back with valid held high and inputs changing mid-operation.
    do_op(7, 11, 2, 1'b1);
    do_op(9, 6, 0, 1'b1);
    do_op(2, 13, 1, 1'b1);
    do_op(14, 7, 3, 1'b0);
    idle(1);

    // Reset in the middle of a multiply.
    check_eq("ready_before_abort", int'(ready), 1);
    data1   = 4'd13;
    data2   = 4'd14;
    control = 2'b10;
    valid   = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_ready", int'(ready), 0);
    check_eq("abort_result", int'(result), 0);
    last_exp = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("recover_ready", int'(ready), 1);
    check_eq("recover_result", int'(result), 0);
    do_op(6, 9, 2, 1'b0);

    // Randomized operations with random idle gaps and occasional held valid.
    for (int i = 0; i < 24; i++) begin
      int ra, rb, rop;
      bit hold;
      ra   = $urandom_range(0, 15);
      rb   = $urandom_range(0, 15);
      rop  = $urandom_range(0, 3);
      hold = ($urandom_range(0, 3) == 0) && (i != 23);
      do_op(ra, rb, rop, hold);
      if (!hold) idle($urandom_range(0, 3));
    end

    idle(2);
    check_eq("pending_results", exp_q.size(), 0);
    check_eq("result_count", n_res, n_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
